// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter FSM encoding and the default sizing constants so that
// every arbiter variant and its benches agree on them.
package fifo_arb_pkg;

    // Default sizing used by the top-level parameters.
    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 64;
    localparam int MAX_BURST_DEF = 16;

    // State encodings kept as plain constants so legacy code that compares
    // raw state bits keeps working alongside the typed enum.
    localparam logic [0:0] ST_IDLE_ENC  = 1'b0;
    localparam logic [0:0] ST_GRANT_ENC = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE_ENC,
        GRANT = ST_GRANT_ENC
    } arb_state_e;

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot choice of the first set request after last_owner.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is registered.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the requester served most recently
//   pick       - one-hot winner, all-zero when no request is set
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_owner,
    output logic [N-1:0]         pick
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk the ring starting one past last_owner; offset N wraps back onto
    // last_owner itself, so a lone repeat requester still wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last_owner) + i) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time burst words into a FIFO.
// Latency: grant registered one cycle after a request is seen in IDLE; one idle bubble between grants.
// Backpressure: fifo_full stalls the owner (req_ready low) and the grant is held indefinitely.
//
// Ports:
//   clk, rstn          - clock (rising edge) and asynchronous active-low reset
//   req_valid/req_last - per-requester word valid and end-of-burst marker
//   req_data           - requester i occupies bits [i*DATA_W +: DATA_W]
//   req_ready          - per-requester accept strobe (qualify with req_valid)
//   fifo_full          - downstream FIFO full flag
//   fifo_wen/fifo_wdata- downstream FIFO write port
//   grant              - registered one-hot owner, zero when idle
//   busy               - high while a grant is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wen,
    output logic [DATA_W-1:0]       fifo_wdata,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [CNT_W-1:0] BURST_CAP  = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] owner_idx;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic             owner_vld;
    logic             owner_last;
    logic             beat_acc;
    logic             burst_end;

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    // Owner index recovered from the one-hot grant; only meaningful in GRANT.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
    end

    // One-hot AND-OR mux; resolves to zero when idle, which is harmless since
    // fifo_wen is low then.
    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_wdata = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy         = (state_q == GRANT);
    assign owner_vld    = |(req_valid & grant_q);
    assign owner_last   = |(req_last  & grant_q);
    assign beat_acc     = busy && owner_vld && !fifo_full;
    assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);
    // Release on whichever arrives first: the owner's last beat or the cap.
    assign burst_end    = beat_acc && (owner_last || (beat_cnt_inc == BURST_CAP));

    // Ready depends only on full so the owner sees it even before raising valid.
    assign req_ready = grant_q & {N_REQ{busy && !fifo_full}};
    assign fifo_wen  = beat_acc;
    assign grant     = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // A dropped owner valid or a full FIFO simply holds the grant.
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (burst_end) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        beat_cnt_d   = '0;
                        last_owner_d = owner_idx;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // last_owner resets to the top index so requester 0 is favoured first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            last_owner_q <= LAST_RESET;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Latency: n/a.
// Backpressure: bench drives fifo_full directly.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wen;
    logic [DW-1:0]   fifo_wdata;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester behaviour: en gates valid, blen = beats per burst, tot = words to send.
    bit en   [N];
    int blen [N];
    int tot  [N];
    int sent [N];

    logic [N-1:0]  g_log [$];
    logic          w_log [$];
    logic [N-1:0]  r_log [$];
    logic [DW-1:0] d_log [$];

    function automatic logic [DW-1:0] word(int i, int b);
        return {32'(i), 32'(b)};
    endfunction

    task automatic setup();
        g_log.delete();
        w_log.delete();
        r_log.delete();
        d_log.delete();
        for (int i = 0; i < N; i++) begin
            en[i]   = 1'b0;
            blen[i] = 1;
            tot[i]  = 0;
            sent[i] = 0;
        end
        fifo_full = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = en[i] && (sent[i] < tot[i]);
            req_data[i*DW +: DW]    = word(i, sent[i]);
            req_last[i]             = req_valid[i] &&
                                      ((((sent[i] + 1) % blen[i]) == 0) || (sent[i] == tot[i] - 1));
        end
    endtask

    // Sample mid-cycle, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        g_log.push_back(grant);
        w_log.push_back(fifo_wen);
        r_log.push_back(req_ready);
        if (fifo_wen) d_log.push_back(fifo_wdata);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) sent[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = '1;
        req_last  = '1;
        req_data  = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", grant); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", fifo_wen); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [11];
        int           exp_o [5];
        int           exp_b [5];
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp_o = '{0, 1, 2, 3, 0};
        exp_b = '{0, 0, 0, 0, 1};
        setup();
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        tot = '{2, 1, 1, 1};
        for (int c = 0; c < 11; c++) begin
            drive();
            tick();
        end
        for (int c = 0; c < 11; c++) begin
            n_tests++;
            if (g_log[c] !== exp_g[c] || w_log[c] !== (exp_g[c] != '0)) begin
                n_fail++;
                $display("FAIL rr_cycle%0d grant/wen got %b/%b exp %b/%b", c, g_log[c], w_log[c], exp_g[c], exp_g[c] != '0);
            end
        end
        n_tests++; if (d_log.size() != 5) begin n_fail++; $display("FAIL rr_nwrites got %0d exp 5", d_log.size()); end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (d_log[k] !== word(exp_o[k], exp_b[k])) begin
                n_fail++;
                $display("FAIL rr_data%0d got %h exp %h", k, d_log[k], word(exp_o[k], exp_b[k]));
            end
        end
    endtask

    task automatic test_max_burst();
        logic [N-1:0] eg;
        setup();
        en[2] = 1'b1; blen[2] = 20; tot[2] = 20;
        for (int c = 0; c < 23; c++) begin
            drive();
            tick();
        end
        for (int c = 0; c < 23; c++) begin
            eg = ((c >= 1 && c <= 16) || (c >= 18 && c <= 21)) ? 4'b0100 : 4'b0000;
            n_tests++;
            if (g_log[c] !== eg || w_log[c] !== (eg != '0)) begin
                n_fail++;
                $display("FAIL burst_cycle%0d grant/wen got %b/%b exp %b/%b", c, g_log[c], w_log[c], eg, eg != '0);
            end
        end
        n_tests++; if (d_log.size() != 20) begin n_fail++; $display("FAIL burst_nwrites got %0d exp 20", d_log.size()); end
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (d_log[k] !== word(2, k)) begin
                n_fail++;
                $display("FAIL burst_data%0d got %h exp %h", k, d_log[k], word(2, k));
            end
        end
    endtask

    task automatic test_full_stall();
        logic [N-1:0] eg;
        logic         ew;
        setup();
        en[1] = 1'b1; blen[1] = 8; tot[1] = 8;
        for (int c = 0; c < 15; c++) begin
            fifo_full = (c >= 4 && c <= 8);
            drive();
            tick();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 15; c++) begin
            eg = (c >= 1 && c <= 13) ? 4'b0010 : 4'b0000;
            ew = (eg != '0) && !(c >= 4 && c <= 8);
            n_tests++;
            if (g_log[c] !== eg || w_log[c] !== ew || r_log[c] !== (ew ? 4'b0010 : 4'b0000)) begin
                n_fail++;
                $display("FAIL stall_cycle%0d grant/wen/ready got %b/%b/%b exp %b/%b/%b",
                         c, g_log[c], w_log[c], r_log[c], eg, ew, ew ? 4'b0010 : 4'b0000);
            end
        end
        n_tests++; if (d_log.size() != 8) begin n_fail++; $display("FAIL stall_nwrites got %0d exp 8", d_log.size()); end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (d_log[k] !== word(1, k)) begin
                n_fail++;
                $display("FAIL stall_data%0d got %h exp %h", k, d_log[k], word(1, k));
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [N-1:0] eg;
        setup();
        en[3] = 1'b1; blen[3] = 6; tot[3] = 6;
        tot[0] = 1;
        for (int c = 0; c < 10; c++) begin
            en[0] = (c >= 3);
            drive();
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            eg = (c >= 1 && c <= 6) ? 4'b1000 : ((c == 8) ? 4'b0001 : 4'b0000);
            n_tests++;
            if (g_log[c] !== eg || r_log[c][0] !== (c == 8)) begin
                n_fail++;
                $display("FAIL preempt_cycle%0d grant/ready0 got %b/%b exp %b/%b", c, g_log[c], r_log[c][0], eg, c == 8);
            end
        end
        n_tests++; if (d_log.size() != 7) begin n_fail++; $display("FAIL preempt_nwrites got %0d exp 7", d_log.size()); end
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (d_log[k] !== ((k < 6) ? word(3, k) : word(0, 0))) begin
                n_fail++;
                $display("FAIL preempt_data%0d got %h exp %h", k, d_log[k], (k < 6) ? word(3, k) : word(0, 0));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [N-1:0] exp_g [5];
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        setup();
        en[1] = 1'b1; blen[1] = 10; tot[1] = 10;
        for (int c = 0; c < 3; c++) begin
            drive();
            tick();
        end
        drive();
        #1;
        n_tests++;
        if (fifo_wen !== 1'b1 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_pre wen/grant got %b/%b exp 1/0010", fifo_wen, grant);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0000 || fifo_wen !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async grant/wen/busy/ready got %b/%b/%b/%b exp 0000/0/0/0", grant, fifo_wen, busy, req_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (grant !== 4'b0000 || fifo_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold grant/wen got %b/%b exp 0000/0", grant, fifo_wen);
        end
        rstn = 1'b1;
        setup();
        en[0] = 1'b1; tot[0] = 1;
        en[1] = 1'b1; tot[1] = 1;
        for (int c = 0; c < 5; c++) begin
            drive();
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (g_log[c] !== exp_g[c]) begin
                n_fail++;
                $display("FAIL rst_after_cycle%0d grant got %b exp %b", c, g_log[c], exp_g[c]);
            end
        end
        n_tests++;
        if (d_log.size() != 2 || d_log[0] !== word(0, 0) || d_log[1] !== word(1, 0)) begin
            n_fail++;
            $display("FAIL rst_after_data n=%0d d0=%h d1=%h exp 2/%h/%h", d_log.size(), d_log[0], d_log[1], word(0, 0), word(1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_no_preempt();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
